// File: rtl/pwm_pkg.sv
// Shared register map, field positions and address decode for the multi-channel PWM block.
// Center-aligned counting is only built when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;

  localparam int MAX_NUM_CH = 8;
  localparam int CH_IDX_W   = $clog2(MAX_NUM_CH);

  localparam logic [7:0] ADDR_GCTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS   = 8'h04;
  localparam logic [7:0] ADDR_CFG_BASE = 8'h10;
  localparam int         CH_STRIDE     = 8;
  localparam int         CNT_OFFSET    = 4;

  localparam int MODE_LSB   = 16;
  localparam int RUN_LSB    = 16;
  localparam int PERIOD_LSB = 16;
  localparam int DUTY_LSB   = 0;
  localparam int SLOT_W     = 16;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_GCTRL,
    REG_STATUS,
    REG_CFG,
    REG_CNT
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e sel;
    ch_idx_t  ch;
  } reg_dec_t;

  // Misaligned or beyond-last-channel addresses decode to REG_NONE.
  function automatic reg_dec_t decode_addr(input logic [7:0] addr, input int num_ch);
    reg_dec_t dec;
    int       off;
    dec.sel = REG_NONE;
    dec.ch  = '0;
    off     = int'(addr) - int'(ADDR_CFG_BASE);
    if (addr == ADDR_GCTRL) begin
      dec.sel = REG_GCTRL;
    end else if (addr == ADDR_STATUS) begin
      dec.sel = REG_STATUS;
    end else if (off >= 0 && addr[1:0] == 2'b00 && (off / CH_STRIDE) < num_ch) begin
      dec.ch  = ch_idx_t'(off / CH_STRIDE);
      dec.sel = ((off % CH_STRIDE) == CNT_OFFSET) ? REG_CNT : REG_CFG;
    end
    return dec;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow and active period/duty, counter, compare and output flop.
// With PWM_CENTER_ALIGN_EN defined the counter can also run up/down.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic             center,
`endif
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_duty,
  output logic [CNT_W-1:0] shadow_period,
  output logic [CNT_W-1:0] shadow_duty,
  output logic [CNT_W-1:0] cnt,
  output logic             running,
  output logic             pwm
);

  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_duty;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] last;
  logic             reload;

  assign last    = act_period - CNT_W'(1);
  assign running = en && (act_period != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_period <= '0;
      shadow_duty   <= '0;
    end else if (cfg_wr) begin
      shadow_period <= wr_period;
      shadow_duty   <= wr_duty;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  logic down;
  logic down_next;

  // Center mode visits 0..period-1 up then period-1..0 down, so each value appears twice per cycle.
  always_comb begin
    cnt_next  = cnt;
    down_next = down;
    reload    = 1'b0;
    if (!en || act_period == '0) begin
      cnt_next  = '0;
      down_next = 1'b0;
      reload    = 1'b1;
    end else if (!center) begin
      down_next = 1'b0;
      reload    = (cnt == last);
      cnt_next  = reload ? '0 : cnt + CNT_W'(1);
    end else if (!down) begin
      if (cnt == last) down_next = 1'b1;
      else             cnt_next  = cnt + CNT_W'(1);
    end else begin
      if (cnt == '0) begin
        down_next = 1'b0;
        reload    = 1'b1;
      end else begin
        cnt_next = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) down <= 1'b0;
    else          down <= down_next;
  end
`else
  // A disabled or zero-period channel reloads every cycle so it always tracks the shadow.
  always_comb begin
    cnt_next = '0;
    reload   = 1'b1;
    if (en && act_period != '0) begin
      reload   = (cnt == last);
      cnt_next = reload ? '0 : cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      act_period <= '0;
      act_duty   <= '0;
      pwm        <= 1'b0;
    end else begin
      pwm <= en && (cnt < act_duty);
      cnt <= cnt_next;
      if (reload) begin
        act_period <= shadow_period;
        act_duty   <= shadow_duty;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Bus-programmed multi-channel PWM: register decode, GCTRL/STATUS, read mux and channel array.
// Define PWM_CENTER_ALIGN_EN to add per-channel center-aligned mode bits in GCTRL.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        addr,
  input  logic [31:0]       wdata,
  input  logic              wen,
  input  logic              ren,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] pwm_out
);

  reg_dec_t          dec;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] err;
  logic [NUM_CH-1:0] err_set;
  logic [NUM_CH-1:0] cfg_wr;
  logic [NUM_CH-1:0] running;
  logic [CNT_W-1:0]  wr_period;
  logic [CNT_W-1:0]  wr_duty;
  logic [CNT_W-1:0]  sh_period [NUM_CH];
  logic [CNT_W-1:0]  sh_duty   [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt    [NUM_CH];
  logic [31:0]       rd_next;
  logic              gctrl_wr;
  logic              status_wr;
`ifdef PWM_CENTER_ALIGN_EN
  logic [NUM_CH-1:0] center;
`endif

  assign dec       = decode_addr(addr, NUM_CH);
  assign wr_period = wdata[PERIOD_LSB +: CNT_W];
  assign wr_duty   = wdata[DUTY_LSB +: CNT_W];

  // A CFG write with duty above period is rejected and flags the channel instead.
  always_comb begin
    gctrl_wr  = wen && (dec.sel == REG_GCTRL);
    status_wr = wen && (dec.sel == REG_STATUS);
    cfg_wr    = '0;
    err_set   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wen && dec.sel == REG_CFG && dec.ch == ch_idx_t'(i)) begin
        err_set[i] = (wr_duty > wr_period);
        cfg_wr[i]  = !(wr_duty > wr_period);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en  <= '0;
      err <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      center <= '0;
`endif
    end else begin
      if (gctrl_wr) begin
        en <= wdata[NUM_CH-1:0];
`ifdef PWM_CENTER_ALIGN_EN
        center <= wdata[MODE_LSB +: NUM_CH];
`endif
      end
      err <= (status_wr ? (err & ~wdata[NUM_CH-1:0]) : err) | err_set;
    end
  end

  always_comb begin
    rd_next = '0;
    case (dec.sel)
      REG_GCTRL: begin
        rd_next[NUM_CH-1:0] = en;
`ifdef PWM_CENTER_ALIGN_EN
        rd_next[MODE_LSB +: NUM_CH] = center;
`endif
      end
      REG_STATUS: begin
        rd_next[NUM_CH-1:0]        = err;
        rd_next[RUN_LSB +: NUM_CH] = running;
      end
      REG_CFG: begin
        for (int i = 0; i < NUM_CH; i++)
          if (dec.ch == ch_idx_t'(i))
            rd_next = {SLOT_W'(sh_period[i]), SLOT_W'(sh_duty[i])};
      end
      REG_CNT: begin
        for (int i = 0; i < NUM_CH; i++)
          if (dec.ch == ch_idx_t'(i))
            rd_next = 32'(ch_cnt[i]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  rdata <= '0;
    else if (ren)  rdata <= rd_next;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .en            (en[g]),
`ifdef PWM_CENTER_ALIGN_EN
      .center        (center[g]),
`endif
      .cfg_wr        (cfg_wr[g]),
      .wr_period     (wr_period),
      .wr_duty       (wr_duty),
      .shadow_period (sh_period[g]),
      .shadow_duty   (sh_duty[g]),
      .cnt           (ch_cnt[g]),
      .running       (running[g]),
      .pwm           (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: register table, directed PWM sequences and randomized bus traffic.
// A PWM_CENTER_ALIGN_EN build additionally runs a center-aligned duty check.
module tb_pwm_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        addr;
  logic [31:0]       wdata;
  logic              wen;
  logic              ren;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] pwm_out;

  always #5 clk = ~clk;

  pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata),
    .wen(wen), .ren(ren), .rdata(rdata), .pwm_out(pwm_out)
  );

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b1;

  // Reference state: what the spec says each channel holds, as plain integers.
  bit                m_en   [NUM_CH];
  bit                m_err  [NUM_CH];
  int                m_shp  [NUM_CH];
  int                m_shd  [NUM_CH];
  int                m_acp  [NUM_CH];
  int                m_acd  [NUM_CH];
  int                m_cnt  [NUM_CH];
  logic [NUM_CH-1:0] exp_pwm;
  logic [31:0]       exp_rdata;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          wen;
    bit          ren;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic int slot_ch(input logic [7:0] a, input int offset);
    int off;
    off = int'(a) - 16;
    if (off < 0 || (off % 8) != offset || off / 8 >= NUM_CH) return -1;
    return off / 8;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] v;
    int          c;
    v = '0;
    if (a == 8'h00) begin
      for (int i = 0; i < NUM_CH; i++) v[i] = m_en[i];
    end else if (a == 8'h04) begin
      for (int i = 0; i < NUM_CH; i++) begin
        v[i]      = m_err[i];
        v[16 + i] = m_en[i] && (m_acp[i] != 0);
      end
    end else if (slot_ch(a, 0) >= 0) begin
      c = slot_ch(a, 0);
      v = {16'(m_shp[c]), 16'(m_shd[c])};
    end else if (slot_ch(a, 4) >= 0) begin
      v = 32'(m_cnt[slot_ch(a, 4)]);
    end
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_en[i] = 0; m_err[i] = 0; m_shp[i] = 0; m_shd[i] = 0;
      m_acp[i] = 0; m_acd[i] = 0; m_cnt[i] = 0;
    end
    exp_pwm   = '0;
    exp_rdata = '0;
  endfunction

  // Advance the reference by one clock using the values present before the edge.
  function automatic void model_step(input logic [7:0] a, input logic [31:0] d, input bit w, input bit r);
    int c, p, du;
    if (r) exp_rdata = model_read(a);
    for (int i = 0; i < NUM_CH; i++) begin
      exp_pwm[i] = m_en[i] && (m_cnt[i] < m_acd[i]);
      if (!m_en[i] || m_acp[i] == 0) begin
        m_cnt[i] = 0;
        m_acp[i] = m_shp[i]; m_acd[i] = m_shd[i];
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == m_acp[i]) begin
          m_cnt[i] = 0;
          m_acp[i] = m_shp[i]; m_acd[i] = m_shd[i];
        end
      end
    end
    if (w) begin
      c = slot_ch(a, 0);
      if (a == 8'h00) begin
        for (int i = 0; i < NUM_CH; i++) m_en[i] = d[i];
      end else if (a == 8'h04) begin
        for (int i = 0; i < NUM_CH; i++) if (d[i]) m_err[i] = 0;
      end else if (c >= 0) begin
        p  = int'(d[31:16]);
        du = int'(d[15:0]);
        if (du > p) m_err[c] = 1;
        else begin m_shp[c] = p; m_shd[c] = du; end
      end
    end
  endfunction

  task automatic checkOutput();
    if (model_on) begin
      check32("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check32("rdata", rdata, exp_rdata);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d, input bit w, input bit r);
    addr = a; wdata = d; wen = w; ren = r;
    if (model_on) model_step(a, d, w, r);
    @(posedge clk);
    #1;
    addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic readExpect(input string name, input logic [7:0] a, input logic [31:0] exp);
    applyStimulus(a, 32'h0, 1'b0, 1'b1);
    check32(name, rdata, exp);
  endtask

  task automatic countHigh(input int ch, input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      idle(1);
      if (pwm_out[ch]) highs++;
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check32("reset pwm_out", 32'(pwm_out), 32'h0);
    check32("reset rdata", rdata, 32'h0);
    reset_n = 1'b1;
  endtask

  logic [7:0] rd_addrs [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h13, 8'hFC};

  initial begin
    int highs, guard, op, c, p, du;
    doReset();

    // Register map, reset values, error flag and W1C behaviour.
    vecs.push_back('{8'h00, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h04, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h10, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h14, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h08, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h10, 32'h0064001E, 1, 0, 32'h0});
    vecs.push_back('{8'h10, 32'h0,        0, 1, 32'h0064001E});
    vecs.push_back('{8'h18, 32'h0032003C, 1, 0, 32'h0});
    vecs.push_back('{8'h04, 32'h0,        0, 1, 32'h00000002});
    vecs.push_back('{8'h18, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h04, 32'h00000002, 1, 0, 32'h0});
    vecs.push_back('{8'h04, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h30, 32'hFFFFFFFF, 1, 0, 32'h0});
    vecs.push_back('{8'h30, 32'h0,        0, 1, 32'h0});
    vecs.push_back('{8'h11, 32'h00010001, 1, 0, 32'h0});
    vecs.push_back('{8'h10, 32'h0,        0, 1, 32'h0064001E});
    vecs.push_back('{8'h00, 32'h00000001, 1, 0, 32'h0});
    vecs.push_back('{8'h00, 32'h0,        0, 1, 32'h00000001});
    vecs.push_back('{8'h04, 32'h0,        0, 1, 32'h00010000});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wen, vecs[i].ren);
      if (vecs[i].ren) check32($sformatf("table[%0d]", i), rdata, vecs[i].exp);
    end

    countHigh(0, 100, highs);
    check32("t1 highs per period", 32'(highs), 32'd30);

    // Mid-period duty change takes effect only after the next wrap.
    guard = 0;
    while (m_cnt[0] != 50 && guard < 200) begin idle(1); guard++; end
    applyStimulus(8'h10, 32'h0064003C, 1'b1, 1'b0);
    highs = 0; guard = 0;
    while (m_cnt[0] != 0 && guard < 200) begin
      idle(1); guard++;
      if (pwm_out[0]) highs++;
    end
    check32("t2 remainder highs", 32'(highs), 32'd0);
    countHigh(0, 100, highs);
    check32("t2 new period highs", 32'(highs), 32'd60);

    // Duty boundaries and zero period on ch2.
    applyStimulus(8'h20, 32'h000A0000, 1'b1, 1'b0);
    applyStimulus(8'h00, 32'h00000005, 1'b1, 1'b0);
    idle(15);
    countHigh(2, 20, highs);
    check32("t4 duty0 highs", 32'(highs), 32'd0);
    applyStimulus(8'h20, 32'h000A000A, 1'b1, 1'b0);
    idle(15);
    countHigh(2, 20, highs);
    check32("t4 duty=period highs", 32'(highs), 32'd20);
    applyStimulus(8'h20, 32'h00000000, 1'b1, 1'b0);
    idle(15);
    countHigh(2, 20, highs);
    check32("t4 period0 highs", 32'(highs), 32'd0);
    readExpect("t4 cnt2", 8'h24, 32'h0);
    readExpect("t4 status", 8'h04, 32'h00010000);

    // Two independent channels, then ch0 disabled alone.
    applyStimulus(8'h00, 32'h0, 1'b1, 1'b0);
    applyStimulus(8'h10, 32'h00080003, 1'b1, 1'b0);
    applyStimulus(8'h28, 32'h00050002, 1'b1, 1'b0);
    applyStimulus(8'h00, 32'h00000009, 1'b1, 1'b0);
    idle(2);
    countHigh(0, 40, highs);
    check32("t5 ch0 highs", 32'(highs), 32'd15);
    countHigh(3, 40, highs);
    check32("t5 ch3 highs", 32'(highs), 32'd16);
    applyStimulus(8'h00, 32'h00000008, 1'b1, 1'b0);
    idle(1);
    check32("t5 ch0 off", 32'(pwm_out[0]), 32'h0);
    countHigh(3, 40, highs);
    check32("t5 ch3 after ch0 off", 32'(highs), 32'd16);

    // Randomized bus traffic against the reference.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 9);
      c  = $urandom_range(0, NUM_CH - 1);
      p  = $urandom_range(0, 12);
      du = $urandom_range(0, p + 2);
      case (op)
        4, 5:    applyStimulus(8'(16 + 8 * c), {16'(p), 16'(du)}, 1'b1, 1'b0);
        6:       applyStimulus(8'h00, 32'($urandom_range(0, 15)), 1'b1, 1'b0);
        7:       applyStimulus(8'h04, 32'($urandom_range(0, 15)), 1'b1, 1'b0);
        8:       applyStimulus(rd_addrs[$urandom_range(0, 15)], 32'h0, 1'b0, 1'b1);
        9:       applyStimulus(8'(16 + 8 * c), {16'(p), 16'(du)}, 1'b1, 1'b1);
        default: idle(1);
      endcase
    end

    // Reset asserted while ch0 is driving high.
    doReset();
    applyStimulus(8'h10, 32'h000A0008, 1'b1, 1'b0);
    applyStimulus(8'h00, 32'h00000001, 1'b1, 1'b0);
    applyStimulus(8'h10, 32'h0, 1'b0, 1'b1);
    guard = 0;
    while (exp_pwm[0] != 1'b1 && guard < 30) begin idle(1); guard++; end
    check32("t6 pulse reached", 32'(pwm_out[0]), 32'h1);
    doReset();
    countHigh(0, 10, highs);
    check32("t6 no pulse after reset", 32'(highs), 32'd0);
    readExpect("t6 status", 8'h04, 32'h0);
    readExpect("t6 cfg0", 8'h10, 32'h0);
    readExpect("t6 gctrl", 8'h00, 32'h0);

`ifdef PWM_CENTER_ALIGN_EN
    model_on = 1'b0;
    doReset();
    applyStimulus(8'h10, 32'h000A0004, 1'b1, 1'b0);
    applyStimulus(8'h00, 32'h00010001, 1'b1, 1'b0);
    idle(5);
    countHigh(0, 20, highs);
    check32("center highs", 32'(highs), 32'd8);
    readExpect("center gctrl", 8'h00, 32'h00010001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
